// File: rtl/udp_tx_arbiter_pkg.sv
// udp_tx_arb_pkg: state encoding, default widths and watchdog counter width for udp_tx_arbiter
package udp_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_LEN_W = 12;
  localparam int DEF_MAX_LEN = 1472;
  localparam int TO_W = 16;
endpackage

// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: frame-source side and streamer side of the UDP TX arbiter
interface udp_tx_arbiter_if #(
  parameter int NCH = 4,
  parameter int LEN_W = udp_tx_arb_pkg::DEF_LEN_W
);
  logic [NCH-1:0] req, fifo_rxen_o, grant, done;
  logic [NCH*LEN_W-1:0] len_i;
  logic [NCH*8-1:0] fifo_rxd_i;
  logic tx_fs, tx_fd, st_rxen, err_timeout;
  logic [LEN_W-1:0] tx_len;
  logic [7:0] st_rxd;
  modport slave (
    input req, len_i, fifo_rxd_i, tx_fd, st_rxen,
    output fifo_rxen_o, grant, done, tx_fs, tx_len, st_rxd, err_timeout
  );
  modport master (
    output req, len_i, fifo_rxd_i, tx_fd, st_rxen,
    input fifo_rxen_o, grant, done, tx_fs, tx_len, st_rxd, err_timeout
  );
endinterface

// File: rtl/udp_tx_arbiter_rr_pick.sv
// rr_pick: first set request at or above ptr, wrapping from NCH-1 back to 0
module rr_pick #(
  parameter int NCH = 4,
  localparam int PW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [PW-1:0]  win_o,
  output logic           valid_o
);
  logic [PW-1:0] idx;
  always_comb begin
    win_o = '0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_i) + k) % NCH);
      win_o = req_i[idx] ? idx : win_o;
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin share of one FIFO-to-UDP streamer among NCH frame sources.
// Define UDP_TX_ARB_TIMEOUT_EN to abort frames whose streamer never reports tx_fd.
module udp_tx_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int LEN_W = DEF_LEN_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic clk,
  input logic rst,
  udp_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NCH);
  state_e state_q, state_d;
  logic [PW-1:0] sel_q, sel_d, ptr_q, ptr_d, win;
  logic [NCH-1:0] grant_q, grant_d, done_q, done_d, req_m;
  logic [LEN_W-1:0] len_q, len_d, len_w;
  logic mask_q, mask_d, skip_q, skip_d, win_v, zero, fire;
  // the source just served is hidden for one IDLE cycle so a held req cannot win twice in a row
  assign req_m = bus.req & ~(mask_q ? NCH'(1) << sel_q : '0);
  rr_pick #(.NCH(NCH)) u_pick (.req_i(req_m), .ptr_i(ptr_q), .win_o(win), .valid_o(win_v));
  assign len_w = bus.len_i[win*LEN_W +: LEN_W];
  assign zero = len_w == '0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= state_q == BUSY ? cnt_q + 1'b1 : '0;
  assign fire = state_q == BUSY && !bus.tx_fd && cnt_q == TO_W'(TIMEOUT_CYC - 1);
`else
  assign fire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    len_d = len_q;
    skip_d = skip_q;
    done_d = '0;
    mask_d = 1'b0;
    case (state_q)
      IDLE: if (win_v) begin
        sel_d = win;
        grant_d = NCH'(1) << win;
        len_d = len_w > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len_w;
        skip_d = zero;
        state_d = zero ? DONE : BUSY;
        done_d = zero ? NCH'(1) << win : '0;
      end
      BUSY: if (bus.tx_fd || fire) begin
        state_d = DONE;
        done_d = grant_q;
      end
      // a started frame lingers at least one cycle past its done pulse; a skipped one does not
      DONE: if (!bus.tx_fd && (done_q == '0 || skip_q)) begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d = sel_q == PW'(NCH - 1) ? '0 : sel_q + 1'b1;
        mask_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
      done_q <= '0;
      len_q <= '0;
      mask_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      done_q <= done_d;
      len_q <= len_d;
      mask_q <= mask_d;
      skip_q <= skip_d;
    end
  assign bus.grant = grant_q;
  assign bus.done = done_q;
  assign bus.tx_fs = state_q == BUSY;
  assign bus.tx_len = len_q;
  assign bus.err_timeout = fire;
  assign bus.fifo_rxen_o = (state_q == BUSY && bus.st_rxen) ? NCH'(1) << sel_q : '0;
  assign bus.st_rxd = state_q == BUSY ? bus.fifo_rxd_i[sel_q*8 +: 8] : '0;
endmodule
